// File: rtl/mod_addsub.sv
// Modular add/subtract over a 384-bit odd modulus, built on an external
// 384-bit add/sub unit driven through a start/done handshake (two ops per request).
module mod_addsub (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         subtract,
    input  logic [383:0] in_a,
    input  logic [383:0] in_b,
    input  logic [383:0] modulus,
    output logic [383:0] result,
    output logic         done,
    output logic         busy,
    output logic         add_start,
    output logic         add_subtract,
    output logic [383:0] add_a,
    output logic [383:0] add_b,
    input  logic [384:0] add_result,
    input  logic         add_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE1 = 3'd1;
    localparam logic [2:0] WAIT1  = 3'd2;
    localparam logic [2:0] ISSUE2 = 3'd3;
    localparam logic [2:0] WAIT2  = 3'd4;
    localparam logic [2:0] FIN    = 3'd5;

    logic [2:0]   state;
    logic         op_sub;
    logic [383:0] op_mod;
    logic [384:0] r1;
    logic [384:0] r2;
    logic [384:0] fin_r1;
    logic         fin_sub;

    // Add: r2 = r1 - m; keep r1 only if it neither overflowed nor exceeds m.
    // Sub: r2 = r1 + m, used only when the first op borrowed.
    function automatic logic [383:0] select_result(input logic sub,
                                                   input logic [384:0] s1,
                                                   input logic [384:0] s2);
        logic [383:0] sel;
        if (sub)
            sel = s1[384] ? s2[383:0] : s1[383:0];
        else if (s1[384])
            sel = s2[383:0];
        else if (s2[384])
            sel = s1[383:0];
        else
            sel = s2[383:0];
        return sel;
    endfunction

    // fin_r1/r2/fin_sub change only on entry to FIN, so result holds between completions
    assign result    = select_result(fin_sub, fin_r1, r2);
    assign done      = (state == FIN);
    assign busy      = (state != IDLE);
    assign add_start = (state == ISSUE1) || (state == ISSUE2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_sub       <= 1'b0;
            op_mod       <= '0;
            r1           <= '0;
            r2           <= '0;
            fin_r1       <= '0;
            fin_sub      <= 1'b0;
            add_subtract <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_sub       <= subtract;
                        op_mod       <= modulus;
                        add_a        <= in_a;
                        add_b        <= in_b;
                        add_subtract <= subtract;
                        state        <= ISSUE1;
                    end
                end
                ISSUE1: state <= WAIT1;
                WAIT1: begin
                    if (add_done) begin
                        r1           <= add_result;
                        add_a        <= add_result[383:0];
                        add_b        <= op_mod;
                        add_subtract <= ~op_sub;
                        state        <= ISSUE2;
                    end
                end
                ISSUE2: state <= WAIT2;
                WAIT2: begin
                    if (add_done) begin
                        r2      <= add_result;
                        fin_r1  <= r1;
                        fin_sub <= op_sub;
                        state   <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub.sv
// Bench for mod_addsub: behavioural add/sub unit with programmable latency,
// vector table plus hand-written corner sequences, results checked via a scoreboard.
module tb_mod_addsub;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [383:0] in_a = '0;
    logic [383:0] in_b = '0;
    logic [383:0] modulus = '0;
    logic [383:0] result;
    logic         done;
    logic         busy;
    logic         add_start;
    logic         add_subtract;
    logic [383:0] add_a;
    logic [383:0] add_b;
    logic [384:0] add_result;
    logic         add_done;

    mod_addsub dut (
        .clk(clk), .reset(reset), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .modulus(modulus), .result(result),
        .done(done), .busy(busy), .add_start(add_start), .add_subtract(add_subtract),
        .add_a(add_a), .add_b(add_b), .add_result(add_result), .add_done(add_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic sub; logic [383:0] a; logic [383:0] b; logic [383:0] m; logic [383:0] res; int lat; } vec_t;
    typedef struct { logic [383:0] res; int acc; int lat; } exp_t;
    typedef struct { logic [383:0] res; int cyc; } got_t;

    exp_t exp_q[$];
    got_t got_q[$];
    bit   car_q[$];
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    int   busy_err = 0;
    int   stab_err = 0;
    int   alat = 1;
    int   acnt = 0;
    bit   inj_done = 1'b0;
    logic [384:0] ares = '0;
    logic [384:0] add_calc;
    logic [383:0] sa = '0;
    logic [383:0] sb = '0;
    logic         ss = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Add/sub unit model: result and done appear alat cycles after the add_start cycle
    assign add_calc   = add_subtract ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
    assign add_done   = (acnt == 1) || inj_done;
    assign add_result = ares;

    always @(posedge clk) begin
        if (add_start) begin
            ares <= add_calc;
            acnt <= alat;
            sa   <= add_a;
            sb   <= add_b;
            ss   <= add_subtract;
            car_q.push_back(add_calc[384]);
        end else if (acnt != 0) begin
            acnt <= acnt - 1;
        end
    end

    always @(negedge clk) begin
        if (acnt == 1 && busy && (add_a !== sa || add_b !== sb || add_subtract !== ss))
            stab_err <= stab_err + 1;
        if (done)
            got_q.push_back('{result, cyc});
    end

    function automatic logic [383:0] rnd384();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [383:0] ref_mod(input logic sub, input logic [383:0] a,
                                             input logic [383:0] b, input logic [383:0] m);
        logic [385:0] t;
        if (!sub) begin
            t = {2'b0, a} + {2'b0, b};
            if (t >= {2'b0, m}) t = t - {2'b0, m};
        end else if (a >= b) begin
            t = {2'b0, a} - {2'b0, b};
        end else begin
            t = {2'b0, a} + {2'b0, m} - {2'b0, b};
        end
        return t[383:0];
    endfunction

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int n, input bit scramble, input int hold);
        int i;
        bit exp_busy;
        i = 0;
        while (got_q.size() < n && i < 400) begin
            @(posedge clk);
            #1;
            i++;
            if (hold != 0 && i >= hold) start = 1'b0;
            exp_busy = 1'b0;
            foreach (exp_q[k])
                if (cyc >= exp_q[k].acc && cyc <= exp_q[k].acc + exp_q[k].lat - 2) exp_busy = 1'b1;
            if (busy !== exp_busy) busy_err++;
            if (scramble) begin
                in_a     = rnd384();
                in_b     = rnd384();
                modulus  = rnd384() | 384'd1;
                subtract = ($urandom_range(1) != 0);
            end
        end
        nchk++;
        if (got_q.size() < n) begin
            nerr++;
            $display("FAIL done_timeout: got %0d done pulses want %0d", got_q.size(), n);
        end
    endtask

    task automatic score(input int base, input int nops);
        exp_t e;
        got_t g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL missing_done: got none want result %0h", e.res);
            end else begin
                g = got_q.pop_front();
                chk("result", g.res, e.res);
                chki("latency", g.cyc - e.acc + 2, e.lat);
            end
        end
        chki("extra_done", got_q.size(), 0);
        chki("add_ops", car_q.size() - base, 2 * nops);
        chki("busy_profile", busy_err, 0);
        chki("operand_hold", stab_err, 0);
        got_q.delete();
        busy_err = 0;
    endtask

    task automatic run_op(input vec_t v, input bit scramble, output int base);
        exp_t e;
        alat = v.lat;
        base = car_q.size();
        @(negedge clk);
        in_a = v.a; in_b = v.b; modulus = v.m; subtract = v.sub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = v.res; e.acc = cyc; e.lat = 2 * v.lat + 4;
        exp_q.push_back(e);
        wait_done(1, scramble, 0);
        score(base, 1);
    endtask

    vec_t tv[8];

    initial begin
        logic [383:0] ones;
        int   base;
        int   acc0;
        exp_t e;
        vec_t v;

        ones  = '1;
        tv[0] = '{1'b0, 384'd50, 384'd60, 384'd97, 384'd13, 1};
        tv[1] = '{1'b1, 384'd10, 384'd20, 384'd97, 384'd87, 1};
        tv[2] = '{1'b1, 384'd20, 384'd10, 384'd97, 384'd10, 1};
        tv[3] = '{1'b0, ones - 384'd1, ones - 384'd1, ones, ones - 384'd2, 1};
        tv[4] = '{1'b0, 384'd96, 384'd96, 384'd97, 384'd95, 5};
        tv[5] = '{1'b1, 384'd0, 384'd96, 384'd97, 384'd1, 1};
        for (int i = 6; i < 8; i++) begin
            tv[i].m   = rnd384() | 384'd1;
            tv[i].a   = rnd384() % tv[i].m;
            tv[i].b   = rnd384() % tv[i].m;
            tv[i].sub = (i == 7);
            tv[i].lat = (i == 7) ? 5 : 1;
            tv[i].res = ref_mod(tv[i].sub, tv[i].a, tv[i].b, tv[i].m);
        end

        // Outputs while reset is held
        #3;
        chk("rst_result", result, '0);
        chki("rst_ctrl", int'({done, busy, add_start, add_subtract}), 0);
        chk("rst_add_a", add_a, '0);
        chk("rst_add_b", add_b, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(tv[i], 1'b0, base);
            if (i == 3) chki("r1_carry", int'(car_q[base]), 1);
        end

        // start held for 20 cycles with a 5-cycle unit: accepts only at IDLE
        alat = 5;
        base = car_q.size();
        @(negedge clk);
        in_a = 384'd96; in_b = 384'd96; modulus = 384'd97; subtract = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        acc0 = cyc;
        e.res = 384'd95; e.acc = acc0;      e.lat = 14; exp_q.push_back(e);
        e.res = 384'd95; e.acc = acc0 + 14; e.lat = 14; exp_q.push_back(e);
        wait_done(2, 1'b0, 19);
        start = 1'b0;
        score(base, 2);

        // operands scrambled every cycle after acceptance
        v = '{1'b0, 384'd70, 384'd40, 384'd97, 384'd13, 5};
        run_op(v, 1'b1, base);

        // reset in WAIT1, then stale add_done after release
        alat = 5;
        @(negedge clk);
        in_a = 384'd50; in_b = 384'd60; modulus = 384'd97; subtract = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chki("abort_ctrl", int'({done, busy, add_start, add_subtract}), 0);
        chk("abort_result", result, '0);
        chk("abort_add_a", add_a, '0);
        chk("abort_add_b", add_b, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (10) @(negedge clk);
        chki("abort_no_done", got_q.size(), 0);
        chki("abort_idle", int'({done, busy, add_start}), 0);
        chk("abort_result_hold", result, '0);

        v = '{1'b0, 384'd0, 384'd0, 384'd97, 384'd0, 5};
        run_op(v, 1'b0, base);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
